// File: rtl/register_file.sv
// register_file: 2**SEL_W x DATA_W regs; clk, reset (sync, high), replaceData/replaceSel write every edge, A_sel/B_sel -> A/B combinational reads
module register_file #(
  parameter int DATA_W = 8,
  parameter int SEL_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] replaceData,
  input  logic [SEL_W-1:0]  replaceSel,
  input  logic [SEL_W-1:0]  A_sel,
  input  logic [SEL_W-1:0]  B_sel,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B
);
  logic [DATA_W-1:0] r [2**SEL_W];
  always_ff @(posedge clk)
    if (reset) for (int i = 0; i < 2**SEL_W; i++) r[i] <= '0;
    else r[replaceSel] <= replaceData;
  assign A = r[A_sel];
  assign B = r[B_sel];
endmodule

// File: tb/tb_register_file.sv
// tb_register_file: directed checks of register_file writes, reads, no-bypass and reset
module tb_register_file;
  logic       clk = 0;
  logic       reset;
  logic [7:0] replaceData;
  logic [3:0] replaceSel;
  logic [3:0] A_sel;
  logic [3:0] B_sel;
  logic [7:0] A;
  logic [7:0] B;
  int total = 0;
  int bad = 0;
  register_file dut (
    .clk(clk), .reset(reset), .replaceData(replaceData), .replaceSel(replaceSel),
    .A_sel(A_sel), .B_sel(B_sel), .A(A), .B(B)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic wr(input logic [3:0] s, input logic [7:0] d);
    @(negedge clk);
    replaceSel = s;
    replaceData = d;
    @(posedge clk);
    #1;
  endtask
  task automatic rd(input string tag, input logic [3:0] a, input logic [3:0] b,
                    input logic [7:0] ea, input logic [7:0] eb);
    A_sel = a;
    B_sel = b;
    #1;
    check({tag, "_A"}, A, ea);
    check({tag, "_B"}, B, eb);
  endtask
  task automatic all_zero(input string tag);
    for (int i = 0; i < 16; i++) rd($sformatf("%s%0d", tag, i), 4'(i), 4'(15 - i), 8'h00, 8'h00);
  endtask
  initial begin
    reset = 1;
    replaceSel = 0;
    replaceData = 8'hFF;
    A_sel = 0;
    B_sel = 0;
    repeat (2) @(posedge clk);
    #1;
    all_zero("rst");
    @(negedge clk);
    reset = 0;
    replaceData = 8'hAA;
    wr(0, 8'hAA);
    rd("w0", 0, 0, 8'hAA, 8'hAA);
    wr(1, 8'hBB);
    rd("w1", 1, 0, 8'hBB, 8'hAA);
    wr(2, 8'hCC);
    rd("w2", 2, 1, 8'hCC, 8'hBB);
    wr(15, 8'hDD);
    rd("w15", 15, 2, 8'hDD, 8'hCC);
    wr(10, 8'hEE);
    rd("w10", 10, 15, 8'hEE, 8'hDD);
    rd("keep", 0, 1, 8'hAA, 8'hBB);
    rd("unw", 7, 9, 8'h00, 8'h00);
    wr(3, 8'h11);
    @(negedge clk);
    replaceData = 8'h22;
    A_sel = 3;
    B_sel = 3;
    #1;
    check("nobyp_A", A, 8'h11);
    check("nobyp_B", B, 8'h11);
    @(posedge clk);
    #1;
    check("after_A", A, 8'h22);
    check("after_B", B, 8'h22);
    repeat (3) @(posedge clk);
    #1;
    rd("hold", 3, 2, 8'h22, 8'hCC);
    @(negedge clk);
    reset = 1'bx;
    wr(7, 8'h77);
    rd("xrst", 7, 15, 8'h77, 8'hDD);
    @(negedge clk);
    reset = 1;
    replaceSel = 5;
    replaceData = 8'hFF;
    @(posedge clk);
    #1;
    all_zero("mid");
    @(negedge clk);
    reset = 0;
    replaceSel = 4;
    replaceData = 8'h5A;
    @(posedge clk);
    #1;
    rd("resume", 4, 5, 8'h5A, 8'h00);
    rd("resume0", 0, 15, 8'h00, 8'h00);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 Parameter DATA_W, default 8: width of each register and of the read/write data ports.
REQ-002 Parameter SEL_W, default 4: select width; register count is 2**SEL_W (16 at default).
REQ-003 clk  input  1  single clock; all state updates occur on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset sampled on the rising clk edge.
REQ-005 replaceData  input  DATA_W  write data.
REQ-006 replaceSel  input  SEL_W  write address; there is no separate write enable.
REQ-007 A_sel  input  SEL_W  read address for port A.
REQ-008 B_sel  input  SEL_W  read address for port B.
REQ-009 A  output  DATA_W  contents of register A_sel.
REQ-010 B  output  DATA_W  contents of register B_sel.

Function
REQ-011 The block SHALL hold 2**SEL_W registers of DATA_W bits each, indexed 0 to 2**SEL_W-1 (r0..r15 at default).
REQ-012 On every rising clk edge with reset low, the block SHALL write replaceData into register replaceSel, unconditionally.
REQ-013 Each write SHALL update exactly one register; all other registers SHALL keep their values.
REQ-014 Reads SHALL be combinational: A = r[A_sel] and B = r[B_sel], with zero-cycle latency after a select change.
REQ-015 A newly written value SHALL appear on A or B immediately after the writing edge, with no extra cycle.
REQ-016 When A_sel or B_sel equals replaceSel before an edge, that port SHALL show the old value; no write-through bypass.
REQ-017 A_sel and B_sel SHALL be fully independent and may select the same register; both ports then show identical data.
REQ-018 Every select value 0 to 2**SEL_W-1, including the top index 15, SHALL be valid; no out-of-range case exists.
REQ-019 Holding replaceSel and replaceData constant across several edges SHALL rewrite the same value each edge, with no side effect.
REQ-020 An X or Z value on reset SHALL be treated as deasserted, so writes proceed when reset is left undriven.

Reset
REQ-021 While reset is high at a rising clk edge, all registers SHALL be set to 0.
REQ-022 Reset SHALL take priority over the write in the same cycle; replaceData is discarded on that edge.
REQ-023 Registers SHALL have no defined value before the first reset or write edge.
REQ-024 A and B SHALL read 0 for every select value after a reset edge, until a later write to that register.
REQ-025 Reset asserted in the middle of a write sequence SHALL clear all registers on that edge; writes resume on the first edge with reset low.

Verification
REQ-026 replaceSel=0, replaceData=0xAA, one edge; then A_sel=B_sel=0 -> A=0xAA, B=0xAA.
REQ-027 Write 0xBB to r1; A_sel=1, B_sel=0 -> A=0xBB, B=0xAA. Then write 0xCC to r2; A_sel=2, B_sel=1 -> A=0xCC, B=0xBB.
REQ-028 Write 0xDD to r15; A_sel=15, B_sel=2 -> A=0xDD, B=0xCC. Then write 0xEE to r10; A_sel=10, B_sel=15 -> A=0xEE, B=0xDD.
REQ-029 A_sel=replaceSel=3, r3=0x11, replaceData=0x22 -> A=0x11 before the edge and A=0x22 immediately after it.
REQ-030 Registers loaded with nonzero data, then reset high for one edge with replaceData=0xFF -> A=B=0x00 for every select value, including the reset-cycle write target.
